// File: rtl/spi_device_pkg.sv
// Shared constants for the SPI responder: register offsets, STATUS bit layout
// and the transfer FSM state type.
package spi_device_pkg;

    localparam int unsigned OFF_RXDATA = 32'h0;
    localparam int unsigned OFF_STATUS = 32'h4;
    localparam int unsigned OFF_TXDATA = 32'h8;

    localparam int STAT_RX_EMPTY  = 0;
    localparam int STAT_RX_FULL   = 1;
    localparam int STAT_TX_EMPTY  = 2;
    localparam int STAT_TX_FULL   = 3;
    localparam int STAT_OVERFLOW  = 4;
    localparam int STAT_UNDERRUN  = 5;
    localparam int STAT_CS_ACTIVE = 6;
    localparam int STAT_W         = 7;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } spi_state_e;

endpackage

// File: rtl/spi_device_if.sv
// Device-bus request/response bundle shared by the host side and the responder.
interface spi_device_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 device_req;
    logic [AddrWidth-1:0] device_addr;
    logic                 device_we;
    logic [3:0]           device_be;
    logic [DataWidth-1:0] device_wdata;
    logic                 device_rvalid;
    logic [DataWidth-1:0] device_rdata;

    modport master (
        output device_req, device_addr, device_we, device_be, device_wdata,
        input  device_rvalid, device_rdata
    );

    modport slave (
        input  device_req, device_addr, device_we, device_be, device_wdata,
        output device_rvalid, device_rdata
    );
endinterface

// File: rtl/spi_dev_fifo.sv
// Synchronous FIFO with first-word fall-through head; a push into a full FIFO
// succeeds only when a pop happens in the same cycle.
module spi_dev_fifo #(
    parameter int Width = 8,
    parameter int Depth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [Width-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [Width-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(Depth):0] depth_o
);
    localparam int AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wptr_q, rptr_q;
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign depth_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/spi_device_top.sv
// SPI responder: oversampled host pins feed an RX FIFO, a TX FIFO feeds miso,
// and both are reachable through the request/rvalid register bus.
module spi_device_top
    import spi_device_pkg::*;
#(
    parameter bit          CPOL       = 1'b0,
    parameter bit          CPHA       = 1'b0,
    parameter int          AddrWidth  = 32,
    parameter int          DataWidth  = 32,
    parameter int          RegAddr    = 12,
    parameter int          FifoDepth  = 16,
    parameter logic [7:0]  TxIdleByte = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    spi_device_if.slave bus,
    input  logic       sck_i,
    input  logic       cs_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       irq_o
);
    localparam bit SampleRise = (CPOL == CPHA);
    localparam int DW         = $clog2(FifoDepth) + 1;

    logic [1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic       sck_prev_q;
    logic       sck_s, cs_s, mosi_s, sck_rise, sck_fall;

    spi_state_e state_q, state_d;
    logic       enter, leave, in_xfer, sample_edge, shift_edge, byte_done;

    logic [2:0] bit_cnt_q;
    logic [6:0] rx_sr_q;
    logic [7:0] rx_byte;
    logic [7:0] tx_sr_q, tx_hold_q, tx_fetch_byte;
    logic       hold_vld_q, tx_fetch;

    logic          rx_push, rx_pop, rx_full, rx_empty;
    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    rx_head, tx_head;
    logic [DW-1:0] rx_depth, tx_depth;

    logic                 ovf_q, udr_q, ovf_set, udr_set, ovf_clr, udr_clr;
    logic [RegAddr-1:0]   addr_off;
    logic                 bus_rd, bus_wr;
    logic [STAT_W-1:0]    status;
    logic                 rvalid_q;
    logic [DataWidth-1:0] rdata_q, rdata_d;

    // Two-flop synchronizers; reset values match the idle pin levels so no edge
    // is seen when reset releases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync_q  <= {2{CPOL}};
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sck_prev_q  <= CPOL;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            cs_sync_q   <= {cs_sync_q[0], cs_ni};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_sync_q[1];
        end
    end

    assign sck_s    = sck_sync_q[1];
    assign cs_s     = cs_sync_q[1];
    assign mosi_s   = mosi_sync_q[1];
    assign sck_rise = sck_s && !sck_prev_q;
    assign sck_fall = !sck_s && sck_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no latch can form.
    always_comb begin
        state_d = state_q;
        enter   = 1'b0;
        leave   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!cs_s) begin
                    state_d = S_ACTIVE;
                    enter   = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                    leave   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign in_xfer     = (state_q == S_ACTIVE) && !cs_s;
    assign sample_edge = in_xfer && (SampleRise ? sck_rise : sck_fall);
    assign shift_edge  = in_xfer && (SampleRise ? sck_fall : sck_rise);
    assign byte_done   = sample_edge && (bit_cnt_q == 3'd7);
    assign rx_byte     = {rx_sr_q, mosi_s};

    assign tx_fetch      = enter || byte_done;
    assign tx_pop        = tx_fetch && !tx_empty;
    assign tx_fetch_byte = tx_empty ? TxIdleByte : tx_head;
    assign udr_set       = tx_fetch && tx_empty;

    assign rx_push = byte_done;
    assign ovf_set = byte_done && rx_full && !rx_pop;

    // A fetched byte waits in tx_hold_q and is presented on the next shift edge,
    // so miso only moves on shift edges; CPHA=0 must show the MSB at selection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= TxIdleByte;
            tx_hold_q  <= TxIdleByte;
            hold_vld_q <= 1'b0;
        end else if (leave) begin
            bit_cnt_q  <= '0;
            rx_sr_q    <= '0;
            tx_sr_q    <= TxIdleByte;
            hold_vld_q <= 1'b0;
        end else begin
            if (sample_edge) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_sr_q   <= rx_byte[6:0];
            end
            if (shift_edge) begin
                if (hold_vld_q) begin
                    tx_sr_q    <= tx_hold_q;
                    hold_vld_q <= 1'b0;
                end else begin
                    tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                end
            end
            if (tx_fetch) begin
                if (!CPHA && enter) begin
                    tx_sr_q <= tx_fetch_byte;
                end else begin
                    tx_hold_q  <= tx_fetch_byte;
                    hold_vld_q <= 1'b1;
                end
            end
        end
    end

    assign miso_o = tx_sr_q[7];

    spi_dev_fifo #(.Width(8), .Depth(FifoDepth)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (rx_push),
        .wdata_i (rx_byte),
        .pop_i   (rx_pop),
        .rdata_o (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .depth_o (rx_depth)
    );

    spi_dev_fifo #(.Width(8), .Depth(FifoDepth)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_push),
        .wdata_i (bus.device_wdata[7:0]),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .depth_o (tx_depth)
    );

    assign addr_off = bus.device_addr[RegAddr-1:0];
    assign bus_rd   = bus.device_req && !bus.device_we;
    assign bus_wr   = bus.device_req && bus.device_we;
    assign rx_pop   = bus_rd && (addr_off == RegAddr'(OFF_RXDATA)) && !rx_empty;
    assign tx_push  = bus_wr && (addr_off == RegAddr'(OFF_TXDATA)) && bus.device_be[0];
    assign ovf_clr  = bus_wr && (addr_off == RegAddr'(OFF_STATUS)) && bus.device_wdata[STAT_OVERFLOW];
    assign udr_clr  = bus_wr && (addr_off == RegAddr'(OFF_STATUS)) && bus.device_wdata[STAT_UNDERRUN];

    always_comb begin
        status                 = '0;
        status[STAT_RX_EMPTY]  = rx_empty;
        status[STAT_RX_FULL]   = rx_full;
        status[STAT_TX_EMPTY]  = tx_empty;
        status[STAT_TX_FULL]   = tx_full;
        status[STAT_OVERFLOW]  = ovf_q;
        status[STAT_UNDERRUN]  = udr_q;
        status[STAT_CS_ACTIVE] = (state_q == S_ACTIVE);
    end

    always_comb begin
        rdata_d = '0;
        if (bus_rd) begin
            if ((addr_off == RegAddr'(OFF_RXDATA)) && !rx_empty) rdata_d = DataWidth'(rx_head);
            else if (addr_off == RegAddr'(OFF_STATUS))          rdata_d = DataWidth'(status);
        end
    end

    // Set wins over a same-cycle W1C so no event is ever lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
        end else begin
            rvalid_q <= bus.device_req;
            rdata_q  <= rdata_d;
            ovf_q    <= (ovf_q && !ovf_clr) || ovf_set;
            udr_q    <= (udr_q && !udr_clr) || udr_set;
        end
    end

    assign bus.device_rvalid = rvalid_q;
    assign bus.device_rdata  = rdata_q;
    assign irq_o             = !rx_empty || ovf_q || udr_q;

    logic unused_bits;
    assign unused_bits = ^{bus.device_addr[AddrWidth-1:RegAddr], bus.device_be[3:1],
                           bus.device_wdata[DataWidth-1:8], rx_depth, tx_depth};

endmodule

// File: doc/spi_device_top.md
# spi_device_top

SPI responder (device-side) peripheral: receives bytes from an external SPI host on `sck_i`/`cs_ni`/`mosi_i` into an RX FIFO and shifts reply bytes from a TX FIFO onto `miso_o`. It is the far end of the existing SPI host path and sits on the same device bus with the same request/rvalid register protocol. All SPI pins are asynchronous to `clk_i` and are oversampled.

## Interface
- `CPOL`, 0, idle level of `sck_i`.
- `CPHA`, 0, 0: sample on leading edge; 1: sample on trailing edge.
- `AddrWidth`, 32, bus address width.
- `DataWidth`, 32, bus data width.
- `RegAddr`, 12, decoded low address bits.
- `FifoDepth`, 16, entries per FIFO (power of two, >=2).
- `TxIdleByte`, 8'hFF, byte sent when the TX FIFO is empty.

- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `device_req_i`  in  1  bus request.
- `device_addr_i`  in  AddrWidth  byte address.
- `device_we_i`  in  1  write enable.
- `device_be_i`  in  4  byte enables.
- `device_wdata_i`  in  DataWidth  write data.
- `device_rvalid_o`  out  1  response valid, one cycle after every request.
- `device_rdata_o`  out  DataWidth  read data.
- `sck_i`  in  1  SPI clock from host, asynchronous.
- `cs_ni`  in  1  chip select, active-low, asynchronous.
- `mosi_i`  in  1  host-to-device data.
- `miso_o`  out  1  device-to-host data.
- `irq_o`  out  1  level: RX FIFO not empty, or overflow/underrun sticky set.

## Operation
- Registers (offset on `device_addr_i[RegAddr-1:0]`):
  - 0x0 RXDATA (R): `{0, rx_head[7:0]}`; a read pops when non-empty; empty read returns 0, no pop.
  - 0x4 STATUS (R/W1C): bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 overflow, bit5 underrun, bit6 cs_active. Writing 1 to bit4/bit5 clears them; other bits ignore writes.
  - 0x8 TXDATA (W): with `device_be_i[0]`, pushes `wdata[7:0]`; dropped silently when full. Reads return 0.
  - Unmapped offsets: reads 0, writes ignored.
- `sck_i`, `cs_ni`, `mosi_i` each pass through a 2-flop synchronizer; `sck` edges are detected on the synchronized signal.
- Sample edge = rising if CPOL==CPHA, else falling; shift edge is the opposite edge.
- FSM: IDLE (cs high) -> ACTIVE on synchronized cs fall; ACTIVE -> IDLE on cs rise, from any bit position.
- On entry to ACTIVE: TX shift register loads the TX FIFO head (pop) or `TxIdleByte` (sets underrun). With CPHA=0, MSB is on `miso_o` immediately; with CPHA=1, the first shift edge presents the MSB.
- MSB first, both directions. 3-bit counter advances on every sample edge. On the 8th sample: byte pushed to RX (if full, byte dropped, overflow set), counter wraps, next TX byte loaded as on entry.
- cs rise mid-byte: partial RX byte discarded, counter cleared, a TX byte already popped is lost (no re-push).
- `miso_o` is driven at all times; in IDLE it holds `TxIdleByte[7]`.

## Timing
- Reset: `device_rvalid_o`=0, `device_rdata_o`=0, `miso_o`=`TxIdleByte[7]`, `irq_o`=0, FIFOs empty, stickies 0, FSM IDLE.
- `device_rvalid_o` and `device_rdata_o` are registered: valid exactly one cycle after `device_req_i`. Pop and W1C take effect on the request cycle.
- Pin-to-action latency: 3 `clk_i` cycles from a pin edge (2 sync + 1 detect). RX byte is visible in STATUS on the following cycle.
- Required: `clk_i` >= 8x SCK frequency; SCK half-period >= 4 `clk_i`.
- Simultaneous FIFO push and pop, including when full, both succeed; depth is unchanged.
- A W1C in the same cycle as a new overflow/underrun event leaves the sticky set.

## Structure
- Package `spi_device_pkg`: register offset constants, STATUS bit indices, FSM state enum.
- One sub-module `spi_dev_fifo` (sync FIFO, sync active-high reset, full/empty/depth), instantiated twice for RX and TX.

## Test plan
- Mode 0: TX push 0xA5; host sends 0x3C -> RXDATA reads 0x3C, host receives 0xA5, STATUS then rx_empty=1, tx_empty=1.
- Modes 1/2/3: host sends 0x81 / 0x7E / 0x01 with TX 0x55 queued -> received values exact, `miso_o` changes only on the shift edge.
- TX empty: 2 host bytes -> host receives 0xFF twice, underrun=1; W1C 0x20 -> 0.
- Overflow: FifoDepth+1 bytes, no reads -> first 16 kept in order, overflow=1, `irq_o`=1.
- cs rise after 5 bits, then full byte 0xC3 -> only 0xC3 in RX.
- Reset asserted mid-byte -> all outputs at reset values next cycle; following transfer is clean.
